sevenseg_scan_driver: RTL and testbench

Time-multiplexed driver for a 4-digit common-anode 7-segment display. It consumes the 16-bit value held by the 16-bit latch stage, snapshots it once per scan frame, decodes each nibble to hexadecimal segment patterns and scans the four digits at a programmable rate. It also provides leading-zero blanking, per-digit decimal points and a 3-bit brightness (duty) control. It sits at the end of the datapath, between the latched measurement value and the board's display pins.

---
 rtl/sevenseg_scan_driver_if.sv | 38 +++
 rtl/sevenseg_scan_driver.sv | 156 +++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_scan_driver_if
// Description : Display bundle for the 4-digit 7-segment scan driver.
//               The master side supplies the value to show and the display
//               controls; the slave side (the driver) returns the digit
//               enables, segments, decimal point and frame marker.
//   value[15:0]     hex value, value[3:0] is digit 0 (rightmost)
//   dp[3:0]         decimal-point request per digit
//   blank_lz        leading-zero blanking enable
//   brightness[2:0] on-time control, 0 dimmest .. 7 brightest
//   anode[3:0]      active-low digit enables
//   seg[6:0]        active-low segments {g,f,e,d,c,b,a}
//   dp_out          active-low decimal point
//   frame_start     one-cycle pulse at the start of each 4-digit frame
// Revision    : 1.0 - initial release
// ============================================================================
interface sevenseg_scan_driver_if;
   logic [15:0] value;
   logic [3:0]  dp;
   logic        blank_lz;
   logic [2:0]  brightness;
   logic [3:0]  anode;
   logic [6:0]  seg;
   logic        dp_out;
   logic        frame_start;

   modport master (
      output value, dp, blank_lz, brightness,
      input  anode, seg, dp_out, frame_start
   );

   modport slave (
      input  value, dp, blank_lz, brightness,
      output anode, seg, dp_out, frame_start
   );
endinterface
`default_nettype wire

// File: rtl/sevenseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_scan_driver
// Description : Time-multiplexed driver for a 4-digit common-anode 7-segment
//               display. Snapshots the value once per frame, decodes each
//               nibble to a hex glyph, scans the digits at SCAN_DIV cycles
//               per slot, with leading-zero blanking, decimal points and a
//               3-bit brightness (on-time) control.
//   qzt_clk   system clock, rising edge
//   reset     asynchronous active-low reset
//   bus       sevenseg_scan_driver_if.slave (value/dp/blank_lz/brightness
//             in, anode/seg/dp_out/frame_start out, all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_scan_driver #(
   parameter int SCAN_DIV = 50000
) (
   input  logic                    qzt_clk,
   input  logic                    reset,
   sevenseg_scan_driver_if.slave   bus
);

   localparam int               PRE_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRE_W-1:0] C_PRE_MAX = PRE_W'(SCAN_DIV - 1);
   localparam logic [23:0]      C_DIV_24  = 24'(SCAN_DIV);
   localparam logic [23:0]      C_ON_MAX  = 24'(SCAN_DIV - 1);

   // Active-high glyph for one hex digit, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_pattern(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'h3F;
         4'h1:    pat = 7'h06;
         4'h2:    pat = 7'h5B;
         4'h3:    pat = 7'h4F;
         4'h4:    pat = 7'h66;
         4'h5:    pat = 7'h6D;
         4'h6:    pat = 7'h7D;
         4'h7:    pat = 7'h07;
         4'h8:    pat = 7'h7F;
         4'h9:    pat = 7'h6F;
         4'hA:    pat = 7'h77;
         4'hB:    pat = 7'h7C;
         4'hC:    pat = 7'h39;
         4'hD:    pat = 7'h5E;
         4'hE:    pat = 7'h79;
         default: pat = 7'h71;
      endcase
      return pat;
   endfunction

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [1:0]       dig_q, dig_d;
   logic [15:0]      snap_value_q, snap_value_d;
   logic [3:0]       snap_dp_q, snap_dp_d;
   logic             snap_blz_q, snap_blz_d;
   logic [3:0]       anode_q, anode_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_out_q, dp_out_d;
   logic             frame_start_q, frame_start_d;

   logic             frame_edge;
   logic [23:0]      on_product;
   logic [23:0]      on_cycles;
   logic [23:0]      pre_ext;
   logic [3:0]       nibble;
   logic [3:0]       blank;
   logic             cur_blank;
   logic             cur_dp;
   logic             in_window;
   logic             digit_en;

   always_comb begin
      pre_d         = pre_q;
      dig_d         = dig_q;
      snap_value_d  = snap_value_q;
      snap_dp_d     = snap_dp_q;
      snap_blz_d    = snap_blz_q;

      // Scan counters: prescaler inside a slot, digit index across slots.
      if (pre_q == C_PRE_MAX) begin
         pre_d = '0;
         dig_d = dig_q + 2'd1;
      end else begin
         pre_d = pre_q + PRE_W'(1);
      end

      // The frame-start cycle is the all-off cycle ahead of digit 0, so the
      // snapshot can change here without a visible tear.
      frame_edge = (pre_q == '0) && (dig_q == 2'd0);
      if (frame_edge) begin
         snap_value_d = bus.value;
         snap_dp_d    = bus.dp;
         snap_blz_d   = bus.blank_lz;
      end

      // Brightness is applied live; 24 bits hold (7+1)*2^20 without overflow.
      on_product = ({21'd0, bus.brightness} + 24'd1) * C_DIV_24;
      on_cycles  = on_product >> 3;
      if (on_cycles > C_ON_MAX) begin
         on_cycles = C_ON_MAX;
      end

      // Leading-zero blanking ripples down from digit 3; digit 0 always shows.
      blank[3] = snap_blz_q && (snap_value_q[15:12] == 4'h0);
      blank[2] = blank[3]   && (snap_value_q[11:8]  == 4'h0);
      blank[1] = blank[2]   && (snap_value_q[7:4]   == 4'h0);
      blank[0] = 1'b0;

      nibble    = snap_value_q[{dig_q, 2'b00} +: 4];
      cur_blank = blank[dig_q];
      cur_dp    = snap_dp_q[dig_q];

      // pre==0 is excluded so every slot starts with all digits dark.
      pre_ext   = 24'(pre_q);
      in_window = (pre_ext >= 24'd1) && (pre_ext <= on_cycles);
      // A blank digit is still enabled when its decimal point must light.
      digit_en  = in_window && (!cur_blank || cur_dp);

      anode_d       = digit_en ? ~(4'b0001 << dig_q) : 4'hF;
      seg_d         = cur_blank ? 7'h7F : ~hex_pattern(nibble);
      dp_out_d      = ~(digit_en & cur_dp);
      frame_start_d = frame_edge;
   end

   always_ff @(posedge qzt_clk or negedge reset) begin
      if (!reset) begin
         pre_q         <= '0;
         dig_q         <= 2'd0;
         snap_value_q  <= 16'h0000;
         snap_dp_q     <= 4'h0;
         snap_blz_q    <= 1'b0;
         anode_q       <= 4'hF;
         seg_q         <= 7'h7F;
         dp_out_q      <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         pre_q         <= pre_d;
         dig_q         <= dig_d;
         snap_value_q  <= snap_value_d;
         snap_dp_q     <= snap_dp_d;
         snap_blz_q    <= snap_blz_d;
         anode_q       <= anode_d;
         seg_q         <= seg_d;
         dp_out_q      <= dp_out_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.anode       = anode_q;
   assign bus.seg         = seg_q;
   assign bus.dp_out      = dp_out_q;
   assign bus.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sevenseg_scan_driver
// Description : Self-checking bench for sevenseg_scan_driver (SCAN_DIV=8).
//               A reference model derives every output from the absolute
//               cycle count since reset release and the display rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scan_driver;
   localparam int D     = 8;
   localparam int FRAME = 4 * D;

   logic qzt_clk;
   logic reset;

   sevenseg_scan_driver_if bus();

   sevenseg_scan_driver #(.SCAN_DIV(D)) dut (
      .qzt_clk (qzt_clk),
      .reset   (reset),
      .bus     (bus)
   );

   initial qzt_clk = 1'b0;
   always #5 qzt_clk = ~qzt_clk;

   int tests = 0;
   int fails = 0;

   // Model state: edges since reset release plus the frame snapshot.
   int          n;
   logic [15:0] s_val;
   logic [3:0]  s_dp;
   logic        s_blz;
   logic [3:0]  e_anode;
   logic [6:0]  e_seg;
   logic        e_dp, e_fs, e_lit;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[d];
   endfunction

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Model of one rising edge; inputs are read as they stand at that edge.
   task automatic model_edge();
      int pre, dig, on;
      logic [3:0] nib, onehot;
      logic blank;
      pre = n % D;
      dig = (n / D) % 4;
      if (pre == 0 && dig == 0) begin
         s_val = bus.value;
         s_dp  = bus.dp;
         s_blz = bus.blank_lz;
      end
      on = ((int'(bus.brightness) + 1) * D) >> 3;
      if (on > D - 1) on = D - 1;
      nib    = 4'((s_val >> (4 * dig)) & 16'hF);
      blank  = s_blz && (dig != 0) && ((s_val >> (4 * dig)) == 16'h0);
      e_lit  = (pre >= 1) && (pre <= on) && (!blank || s_dp[dig]);
      onehot = 4'b0001 << dig;
      e_anode = e_lit ? ~onehot : 4'hF;
      e_seg   = blank ? 7'h7F : ~glyph(nib);
      e_dp    = !(e_lit && s_dp[dig]);
      e_fs    = (pre == 0) && (dig == 0);
      n++;
   endtask

   task automatic tick();
      @(posedge qzt_clk);
      model_edge();
      #1;
      chk("anode", 7'(bus.anode), 7'(e_anode));
      chk("dp_out", 7'(bus.dp_out), 7'(e_dp));
      chk("frame_start", 7'(bus.frame_start), 7'(e_fs));
      // Off the frame-start cycle the model snapshot matches the design's.
      if (!e_fs) chk("seg", bus.seg, e_seg);
   endtask

   task automatic run(input int k);
      repeat (k) tick();
   endtask

   // Advance until the next edge to be modelled sits at the given frame phase.
   task automatic run_to(input int phase);
      int guard;
      guard = 0;
      while ((n % FRAME) != phase && guard <= FRAME) begin
         tick();
         guard++;
      end
      tests++;
      assert ((n % FRAME) == phase) else begin
         fails++;
         $error("FAIL run_to: observed phase %0d expected %0d", n % FRAME, phase);
      end
   endtask

   task automatic release_reset();
      @(negedge qzt_clk);
      reset = 1'b1;
      n     = 0;
      s_val = 16'h0;
      s_dp  = 4'h0;
      s_blz = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_anode"}, 7'(bus.anode), 7'h0F);
      chk({tag, "_seg"}, bus.seg, 7'h7F);
      chk({tag, "_dp_out"}, 7'(bus.dp_out), 7'h01);
      chk({tag, "_frame_start"}, 7'(bus.frame_start), 7'h00);
   endtask

   initial begin
      logic [15:0] v;
      int guard;

      reset          = 1'b0;
      bus.value      = 16'h1A8F;
      bus.dp         = 4'h0;
      bus.blank_lz   = 1'b0;
      bus.brightness = 3'd7;
      n = 0; s_val = 16'h0; s_dp = 4'h0; s_blz = 1'b0;

      // Reset state
      repeat (2) @(posedge qzt_clk);
      #1;
      chk_reset_outputs("reset");
      release_reset();

      // Hex decode, full brightness, two frames
      run(2 * FRAME);

      // Leading-zero blanking
      bus.blank_lz = 1'b1;
      bus.value    = 16'h0030;
      run_to(0);
      run(FRAME);
      bus.value = 16'h0000;
      run_to(0);
      run(FRAME);

      // Snapshot: change value in the digit-1 slot
      bus.blank_lz = 1'b0;
      bus.value    = 16'h1234;
      run_to(0);
      run_to(D + 3);
      bus.value = 16'h5678;
      run(2 * FRAME);

      // Dimmest brightness
      bus.brightness = 3'd0;
      run(2 * FRAME);

      // Decimal point on a blanked digit
      bus.brightness = 3'd7;
      bus.blank_lz   = 1'b1;
      bus.value      = 16'h0005;
      bus.dp         = 4'b0100;
      run_to(0);
      run(FRAME);

      // Randomized inputs, including live brightness changes mid-slot
      for (int i = 0; i < 16; i++) begin
         v = 16'($urandom);
         for (int k = 0; k < 4; k++)
            if ($urandom_range(0, 2) == 0) v[4*k +: 4] = 4'h0;
         bus.value      = v;
         bus.dp         = 4'($urandom);
         bus.blank_lz   = 1'($urandom);
         bus.brightness = 3'($urandom);
         run($urandom_range(5, 40));
      end

      // Asynchronous reset while digit 1 is lit
      bus.value      = 16'h1A8F;
      bus.dp         = 4'h0;
      bus.blank_lz   = 1'b0;
      bus.brightness = 3'd7;
      guard = 0;
      do begin
         tick();
         guard++;
      end while (e_anode != 4'b1101 && guard < 3 * FRAME);
      tests++;
      assert (e_anode == 4'b1101) else begin
         fails++;
         $error("FAIL wait_1101: observed %b expected 1101", e_anode);
      end
      #2;
      reset = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      @(posedge qzt_clk);
      #1;
      chk_reset_outputs("held_reset");
      release_reset();
      run(FRAME + 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
